// File: rtl/gpu_loader.sv
// Host-driven loader: writes GPU instruction/data RAM, runs the GPU, reads data back.
// Define GPU_LOADER_READBACK_EN to enable the READ_DATA command.
module gpu_loader #(
    parameter int WORD_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WORD_WIDTH-1:0]    cmd_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_WIDTH-1:0]    rsp_data,
    output logic                     busy,
    output logic                     gpu_run,
    input  logic                     gpu_halted,
    input  logic                     gpu_exception,
    output logic                     gpu_inst_write,
    output logic [ADDRESS_WIDTH-1:0] gpu_inst_address,
    output logic [WORD_WIDTH-1:0]    gpu_inst_data,
    output logic                     gpu_data_write,
    output logic [ADDRESS_WIDTH-1:0] gpu_data_address,
    output logic [WORD_WIDTH-1:0]    gpu_data_wdata,
    input  logic [WORD_WIDTH-1:0]    gpu_data_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_INST,
        WR_DATA,
        RUN,
        RESP
`ifdef GPU_LOADER_READBACK_EN
        ,
        RD_ADDR,
        RD_WAIT,
        RD_SEND
`endif
    } state_t;

    localparam logic [3:0] OP_WR_INST = 4'd0;
    localparam logic [3:0] OP_WR_DATA = 4'd1;
    localparam logic [3:0] OP_RUN     = 4'd2;
`ifdef GPU_LOADER_READBACK_EN
    localparam logic [3:0] OP_RD_DATA = 4'd3;
`endif

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [11:0]              cnt_q, cnt_d;
    logic [23:0]              cycles_q, cycles_d;
    logic [WORD_WIDTH-1:0]    rsp_q, rsp_d;

    logic                     cmd_rdy, rsp_vld, run, inst_we, data_we;
    logic [3:0]               hdr_op;
    logic [11:0]              hdr_cnt;
    logic [ADDRESS_WIDTH-1:0] hdr_addr;
    logic [ADDRESS_WIDTH-1:0] addr_inc;
    logic [23:0]              cyc_inc;
    logic                     last_word;

    assign hdr_op    = cmd_data[31:28];
    assign hdr_cnt   = cmd_data[27:16];
    assign hdr_addr  = ADDRESS_WIDTH'(cmd_data[15:0]);
    assign addr_inc  = addr_q + ADDRESS_WIDTH'(4);
    assign cyc_inc   = (cycles_q == 24'hFFFFFF) ? cycles_q : cycles_q + 24'd1;
    assign last_word = (cnt_q == 12'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            cycles_q <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            cycles_q <= cycles_d;
            rsp_q    <= rsp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        cycles_d = cycles_q;
        rsp_d    = rsp_q;
        cmd_rdy  = 1'b0;
        rsp_vld  = 1'b0;
        run      = 1'b0;
        inst_we  = 1'b0;
        data_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_rdy = 1'b1;
                if (cmd_valid) begin
                    addr_d   = hdr_addr;
                    cnt_d    = hdr_cnt;
                    cycles_d = '0;
                    case (hdr_op)
                        OP_WR_INST: if (hdr_cnt != 12'd0) state_d = WR_INST;
                        OP_WR_DATA: if (hdr_cnt != 12'd0) state_d = WR_DATA;
                        OP_RUN:     state_d = RUN;
`ifdef GPU_LOADER_READBACK_EN
                        OP_RD_DATA: if (hdr_cnt != 12'd0) state_d = RD_ADDR;
`endif
                        default: begin
                            rsp_d   = WORD_WIDTH'(32'hBAD0_0000 | {28'd0, hdr_op});
                            state_d = RESP;
                        end
                    endcase
                end
            end
            WR_INST, WR_DATA: begin
                cmd_rdy = 1'b1;
                inst_we = cmd_valid && (state_q == WR_INST);
                data_we = cmd_valid && (state_q == WR_DATA);
                if (cmd_valid) begin
                    addr_d = addr_inc;
                    cnt_d  = cnt_q - 12'd1;
                    if (last_word) state_d = IDLE;
                end
            end
            RUN: begin
                run      = 1'b1;
                cycles_d = cyc_inc;
                // The cycle in which halt is seen still counts as a run cycle.
                if (gpu_halted || gpu_exception) begin
                    rsp_d   = WORD_WIDTH'({gpu_exception, gpu_halted, 6'b0, cyc_inc});
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_vld = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
`ifdef GPU_LOADER_READBACK_EN
            RD_ADDR: state_d = RD_WAIT;
            RD_WAIT: begin
                rsp_d   = gpu_data_rdata;
                state_d = RD_SEND;
            end
            RD_SEND: begin
                rsp_vld = 1'b1;
                if (rsp_ready) begin
                    addr_d  = addr_inc;
                    cnt_d   = cnt_q - 12'd1;
                    state_d = last_word ? IDLE : RD_ADDR;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifndef GPU_LOADER_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^gpu_data_rdata;
`endif

    // Outputs are forced quiet while reset is held, before state settles.
    assign cmd_ready        = cmd_rdy & ~reset;
    assign rsp_valid        = rsp_vld & ~reset;
    assign rsp_data         = reset ? '0 : rsp_q;
    assign busy             = (state_q != IDLE) & ~reset;
    assign gpu_run          = run & ~reset;
    assign gpu_inst_write   = inst_we & ~reset;
    assign gpu_data_write   = data_we & ~reset;
    assign gpu_inst_address = addr_q;
    assign gpu_data_address = addr_q;
    assign gpu_inst_data    = cmd_data;
    assign gpu_data_wdata   = cmd_data;

endmodule
